// File: rtl/uart_rx_deserializer.sv
// Serial receive framer: start-bit detect, per-strobe bit capture, parity/stop checks,
// and a one-entry valid/ready holding register with sticky overrun.
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 sample,
  output logic                 timer_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic                 sync1, rx_s, rx_d, fall;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 perr, perr_nxt;
  logic                 ts_nxt;
  logic                 commit;
  logic                 ferr;
  logic                 accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  assign fall = !rx_s && rx_d;
  assign ferr = !rx_s;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      perr        <= 1'b0;
      timer_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      shreg       <= shreg_nxt;
      perr        <= perr_nxt;
      timer_start <= ts_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    perr_nxt  = perr;
    ts_nxt    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          ts_nxt    = 1'b1;
          perr_nxt  = 1'b0;
        end
      end
      START: begin
        // The timer is being re-phased while timer_start is high; its strobe is stale.
        if (sample && !timer_start) begin
          if (!rx_s) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          cnt_nxt   = cnt + CW'(1);
          if (cnt == CW'(DATA_BITS - 1))
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample) begin
          perr_nxt  = ((^shreg) ^ rx_s) != (PARITY_ODD != 0);
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = commit && (!rx_valid || rx_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_valid      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (accept) begin
        rx_data       <= shreg;
        rx_parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
        rx_frame_err  <= ferr;
        rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // A new overrun takes priority over a simultaneous clear.
      if (commit && !accept)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

endmodule
